mux_tree_pipe: RTL and testbench

- Parametrised successor to the team's 2:1/4:1 mux primitives: a 2^SEL_W-channel, WIDTH-bit multiplexer built as a binary tree of 2:1 stages.
- Adds optional per-level pipelining, valid/ready flow control with a global stall, and a selected-channel tag that travels with the data.
- Serves as the data-path selector in front of downstream registered consumers.

---
 rtl/mux_tree_pkg.sv | 24 ++
 rtl/mux2_stage.sv | 68 ++++++
 rtl/mux_tree_pipe.sv | 78 +++++++
 tb/tb_mux_tree_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_tree_pkg.sv
// Shared helpers for the pipelined mux tree: channel count, latency and
// flat-bus slicing arithmetic used when unpacking the input channels.
package mux_tree_pkg;

   // Number of channels addressed by a select of the given width.
   function automatic int num_ch(input int sel_w);
      return 32'sd1 << sel_w;
   endfunction

   // Cycles from beat acceptance to out_valid for a given configuration.
   function automatic int lat(input bit pipe, input int sel_w);
      if (pipe) begin
         return sel_w;
      end else begin
         return 32'sd1;
      end
   endfunction

   // Low bit index of channel idx inside a flat bus of width-bit channels.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/mux2_stage.sv
// One 2:1 node of the mux tree. The selected payload and the beat's tag and
// valid either pass straight through or are captured in a stage register that
// holds while the pipeline is stalled.
module mux2_stage #(
   parameter int WIDTH = 8,
   parameter int TAGW  = 2,
   parameter bit REG   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   input  logic [TAGW-1:0]  tag,
   input  logic             v,
   output logic [WIDTH-1:0] y,
   output logic [TAGW-1:0]  y_tag,
   output logic             y_v
);

   logic [WIDTH-1:0] mux_s;

   // Choose between the even (s=0) and odd (s=1) child.
   always_comb begin
      mux_s = a;
      if (s) begin
         mux_s = b;
      end else begin
         mux_s = a;
      end
   end

   generate
      if (REG) begin : g_reg
         logic [WIDTH-1:0] y_r;
         logic [TAGW-1:0]  tag_r;
         logic             v_r;

         // Stage register: valid tracks every advance so bubbles move on,
         // while payload and tag only update on a real beat.
         always_ff @(posedge clk) begin
            if (rst) begin
               y_r   <= {WIDTH{1'b0}};
               tag_r <= {TAGW{1'b0}};
               v_r   <= 1'b0;
            end else if (advance) begin
               v_r <= v;
               if (v) begin
                  y_r   <= mux_s;
                  tag_r <= tag;
               end
            end
         end

         assign y     = y_r;
         assign y_tag = tag_r;
         assign y_v   = v_r;
      end else begin : g_comb
         logic unused_s;
         assign unused_s = ^{clk, rst, advance};
         assign y     = mux_s;
         assign y_tag = tag;
         assign y_v   = v;
      end
   endgenerate

endmodule

// File: rtl/mux_tree_pipe.sv
// 2^SEL_W-channel, WIDTH-bit multiplexer built as a binary tree of 2:1 nodes
// with optional per-level registers, valid/ready flow control and a select
// tag that travels alongside the data.
module mux_tree_pipe
   import mux_tree_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2,
   parameter bit PIPE  = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [num_ch(SEL_W)*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]              in_sel,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [SEL_W-1:0]              out_sel,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int N    = num_ch(SEL_W);
   // Node storage: leaves at 0..N-1, then each tree level packed after the
   // previous one; the root lands at the last index.
   localparam int ROOT = 32'sd2 * N - 32'sd2;

   logic [WIDTH-1:0] node_data [0:ROOT];
   logic [SEL_W-1:0] node_tag  [0:ROOT];
   logic             node_v    [0:ROOT];
   logic             advance_s;

   // A global stall: nothing moves unless the output slot is free or drains.
   assign advance_s = !out_valid || out_ready;
   assign in_ready  = advance_s;

   genvar i, k, j;
   generate
      for (i = 0; i < N; i++) begin : g_leaf
         assign node_data[i] = in_data[slice_lo(i, WIDTH) +: WIDTH];
         assign node_tag[i]  = in_sel;
         assign node_v[i]    = in_valid;
      end

      for (k = 0; k < SEL_W; k++) begin : g_lvl
         localparam int IB  = 32'sd2 * N - 32'sd2 * (N >> k);
         localparam int OB  = 32'sd2 * N - (N >> k);
         localparam int CNT = N >> (k + 32'sd1);
         // The last level is always registered so the outputs come from flops.
         localparam bit REG = PIPE || (k == SEL_W - 32'sd1);
         for (j = 0; j < CNT; j++) begin : g_node
            // Both children carry the same beat, so tag/valid follow the even one.
            mux2_stage #(
               .WIDTH (WIDTH),
               .TAGW  (SEL_W),
               .REG   (REG)
            ) u_node (
               .clk     (clk),
               .rst     (rst),
               .advance (advance_s),
               .a       (node_data[IB + 32'sd2 * j]),
               .b       (node_data[IB + 32'sd2 * j + 32'sd1]),
               .s       (node_tag[IB + 32'sd2 * j][k]),
               .tag     (node_tag[IB + 32'sd2 * j]),
               .v       (node_v[IB + 32'sd2 * j]),
               .y       (node_data[OB + j]),
               .y_tag   (node_tag[OB + j]),
               .y_v     (node_v[OB + j])
            );
         end
      end
   endgenerate

   assign out_data  = node_data[ROOT];
   assign out_sel   = node_tag[ROOT];
   assign out_valid = node_v[ROOT];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed and randomised checks of mux_tree_pipe in a pipelined 4-channel
// configuration and a combinational 8-channel configuration.
module tb_mux_tree_pipe;

   logic clk;
   int   n_cmp;
   int   n_err;

   // Pipelined: WIDTH=8, SEL_W=2, PIPE=1
   logic        a_rst;
   logic [31:0] a_in_data;
   logic [1:0]  a_in_sel;
   logic        a_in_valid;
   logic        a_in_ready;
   logic [7:0]  a_out_data;
   logic [1:0]  a_out_sel;
   logic        a_out_valid;
   logic        a_out_ready;

   // Combinational tree: WIDTH=16, SEL_W=3, PIPE=0
   logic         b_rst;
   logic [127:0] b_in_data;
   logic [2:0]   b_in_sel;
   logic         b_in_valid;
   logic         b_in_ready;
   logic [15:0]  b_out_data;
   logic [2:0]   b_out_sel;
   logic         b_out_valid;
   logic         b_out_ready;

   mux_tree_pipe #(.WIDTH(8), .SEL_W(2), .PIPE(1'b1)) dut_a (
      .clk(clk), .rst(a_rst), .in_data(a_in_data), .in_sel(a_in_sel),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready)
   );

   mux_tree_pipe #(.WIDTH(16), .SEL_W(3), .PIPE(1'b0)) dut_b (
      .clk(clk), .rst(b_rst), .in_data(b_in_data), .in_sel(b_in_sel),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1;
      tick(); tick();
      a_rst = 1'b0; b_rst = 1'b0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_a_valid: got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'h00) begin n_err++; $display("FAIL reset_a_data: got %h want 00", a_out_data); end
      n_cmp++; if (a_out_sel !== 2'd0) begin n_err++; $display("FAIL reset_a_sel: got %0d want 0", a_out_sel); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_ready: got %b want 1", a_in_ready); end
      n_cmp++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_b_valid: got %b want 0", b_out_valid); end
      n_cmp++; if (b_out_data !== 16'h0000) begin n_err++; $display("FAIL reset_b_data: got %h want 0000", b_out_data); end
   endtask

   // Four back-to-back beats, sel 0..3, latency 2.
   task automatic test_stream();
      a_in_data = {8'd44, 8'd33, 8'd22, 8'd11};
      a_out_ready = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc < 4) begin
            a_in_valid = 1'b1;
            a_in_sel   = 2'(cyc);
         end else begin
            a_in_valid = 1'b0;
         end
         tick();
         if (cyc >= 1 && cyc <= 4) begin
            n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", cyc, a_out_valid); end
            n_cmp++; if (a_out_data !== 8'(11 * cyc)) begin n_err++; $display("FAIL stream_data[%0d]: got %0d want %0d", cyc, a_out_data, 11 * cyc); end
            n_cmp++; if (a_out_sel !== 2'(cyc - 1)) begin n_err++; $display("FAIL stream_sel[%0d]: got %0d want %0d", cyc, a_out_sel, cyc - 1); end
         end else begin
            n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle_valid[%0d]: got %b want 0", cyc, a_out_valid); end
         end
      end
      n_cmp++; if (a_out_data !== 8'd44) begin n_err++; $display("FAIL stream_hold_data: got %0d want 44", a_out_data); end
   endtask

   // Output stalled for three cycles once the first beat appears.
   task automatic test_stall();
      a_in_data = {8'd44, 8'd33, 8'd22, 8'd11};
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_sel = 2'd0;
      tick();
      a_in_sel = 2'd1;
      tick();
      a_out_ready = 1'b0;
      a_in_sel = 2'd2;
      #1;
      n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready_now: got %b want 0", a_in_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (a_out_data !== 8'd11) begin n_err++; $display("FAIL stall_data[%0d]: got %0d want 11", i, a_out_data); end
         n_cmp++; if (a_out_sel !== 2'd0) begin n_err++; $display("FAIL stall_sel[%0d]: got %0d want 0", i, a_out_sel); end
         n_cmp++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, a_out_valid); end
         n_cmp++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b want 0", i, a_in_ready); end
      end
      a_out_ready = 1'b1;
      #1;
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", a_in_ready); end
      tick();
      n_cmp++; if (a_out_data !== 8'd22 || a_out_sel !== 2'd1 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume0: got %0d/%0d/%b want 22/1/1", a_out_data, a_out_sel, a_out_valid); end
      a_in_sel = 2'd3;
      tick();
      n_cmp++; if (a_out_data !== 8'd33 || a_out_sel !== 2'd2 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume1: got %0d/%0d/%b want 33/2/1", a_out_data, a_out_sel, a_out_valid); end
      a_in_valid = 1'b0;
      tick();
      n_cmp++; if (a_out_data !== 8'd44 || a_out_sel !== 2'd3 || a_out_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume2: got %0d/%0d/%b want 44/3/1", a_out_data, a_out_sel, a_out_valid); end
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", a_out_valid); end
   endtask

   // Valid pattern 1,0,1 with sel 3,0,1.
   task automatic test_bubbles();
      a_in_data = {8'd44, 8'd33, 8'd22, 8'd11};
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_sel = 2'd3;
      tick();
      a_in_valid = 1'b0; a_in_sel = 2'd0;
      tick();
      n_cmp++; if (a_out_data !== 8'd44 || a_out_valid !== 1'b1 || a_out_sel !== 2'd3) begin n_err++; $display("FAIL bubble_first: got %0d/%0d/%b want 44/3/1", a_out_data, a_out_sel, a_out_valid); end
      a_in_valid = 1'b1; a_in_sel = 2'd1;
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_gap_valid: got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'd44) begin n_err++; $display("FAIL bubble_gap_data: got %0d want 44", a_out_data); end
      a_in_valid = 1'b0;
      tick();
      n_cmp++; if (a_out_data !== 8'd22 || a_out_valid !== 1'b1 || a_out_sel !== 2'd1) begin n_err++; $display("FAIL bubble_second: got %0d/%0d/%b want 22/1/1", a_out_data, a_out_sel, a_out_valid); end
      tick();
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_drain: got %b want 0", a_out_valid); end
   endtask

   // Reset while two beats are in flight and the output is stalled.
   task automatic test_reset_mid();
      a_in_data = {8'd44, 8'd33, 8'd22, 8'd11};
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_sel = 2'd2;
      tick();
      a_in_sel = 2'd3;
      tick();
      n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 8'd33) begin n_err++; $display("FAIL rstmid_pre: got %0d/%b want 33/1", a_out_data, a_out_valid); end
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      a_in_valid = 1'b0;
      #1;
      n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", a_out_valid); end
      n_cmp++; if (a_out_data !== 8'h00) begin n_err++; $display("FAIL rstmid_data: got %h want 00", a_out_data); end
      n_cmp++; if (a_out_sel !== 2'd0) begin n_err++; $display("FAIL rstmid_sel: got %0d want 0", a_out_sel); end
      n_cmp++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", a_in_ready); end
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_stale[%0d]: got %b want 0", i, a_out_valid); end
      end
   endtask

   // Combinational tree: sweep sel 7..0, latency 1.
   task automatic test_pipe0();
      for (int i = 0; i < 8; i++) begin
         b_in_data[i*16 +: 16] = 16'h1000 + 16'(i);
      end
      b_out_ready = 1'b1;
      for (int c = 0; c < 9; c++) begin
         if (c < 8) begin
            b_in_valid = 1'b1;
            b_in_sel   = 3'(7 - c);
         end else begin
            b_in_valid = 1'b0;
         end
         tick();
         if (c < 8) begin
            n_cmp++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h1000 + 16'(7 - c) || b_out_sel !== 3'(7 - c)) begin
               n_err++; $display("FAIL pipe0[%0d]: got %h/%0d/%b want %h/%0d/1", c, b_out_data, b_out_sel, b_out_valid, 16'h1000 + 16'(7 - c), 7 - c);
            end
         end else begin
            n_cmp++; if (b_out_valid !== 1'b0 || b_out_data !== 16'h1000) begin n_err++; $display("FAIL pipe0_drain: got %h/%b want 1000/0", b_out_data, b_out_valid); end
         end
      end
   endtask

   // Random traffic against a reference queue.
   task automatic test_random();
      logic [9:0] exp_q[$];
      logic [9:0] e;
      for (int cyc = 0; cyc < 10008; cyc++) begin
         if (cyc < 10000) begin
            a_in_data   = $urandom;
            a_in_sel    = 2'($urandom_range(3, 0));
            a_in_valid  = 1'($urandom_range(1, 0));
            a_out_ready = ($urandom_range(3, 0) != 0);
         end else begin
            a_in_valid  = 1'b0;
            a_out_ready = 1'b1;
         end
         #1;
         n_cmp++; if (a_in_ready !== (!a_out_valid || a_out_ready)) begin n_err++; $display("FAIL rand_ready[%0d]: got %b ov %b or %b", cyc, a_in_ready, a_out_valid, a_out_ready); end
         if (a_in_valid && a_in_ready) begin
            exp_q.push_back({a_in_sel, a_in_data[a_in_sel*8 +: 8]});
         end
         if (a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL rand_extra[%0d]: got %0d/%0d want no beat", cyc, a_out_data, a_out_sel);
            end else begin
               e = exp_q.pop_front();
               n_cmp++; if ({a_out_sel, a_out_data} !== e) begin n_err++; $display("FAIL rand_beat[%0d]: got %0d/%0d want %0d/%0d", cyc, a_out_sel, a_out_data, e[9:8], e[7:0]); end
            end
         end
         tick();
      end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drops: got %0d left want 0", exp_q.size()); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      a_rst = 1'b1; a_in_data = 32'h0; a_in_sel = 2'd0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      b_rst = 1'b1; b_in_data = 128'h0; b_in_sel = 3'd0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_bubbles();
      test_reset_mid();
      test_pipe0();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
